// File: rtl/pc_predict_unit_pkg.sv
// Shared types and helpers for the fetch PC / branch predictor unit.
// Condition codes, flag positions, BHT reset value, condition evaluator.
package pc_predict_unit_pkg;

  localparam logic [2:0] COND_NEQ  = 3'b000;
  localparam logic [2:0] COND_EQ   = 3'b001;
  localparam logic [2:0] COND_GT   = 3'b010;
  localparam logic [2:0] COND_LT   = 3'b011;
  localparam logic [2:0] COND_GTE  = 3'b100;
  localparam logic [2:0] COND_LTE  = 3'b101;
  localparam logic [2:0] COND_OVFL = 3'b110;
  localparam logic [2:0] COND_UNC  = 3'b111;

  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_N = 0;

  localparam logic [1:0] BHT_INIT = 2'b01;

  function automatic logic cond_eval(
    input logic [2:0] cond,
    input logic [2:0] flags
  );
    logic z, v, n, r;
    z = flags[FLAG_Z];
    v = flags[FLAG_V];
    n = flags[FLAG_N];
    unique case (cond)
      COND_NEQ:  r = !z;
      COND_EQ:   r = z;
      COND_GT:   r = !z && !n;
      COND_LT:   r = n;
      COND_GTE:  r = z || !n;
      COND_LTE:  r = z || n;
      COND_OVFL: r = v;
      default:   r = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/bht_2bit.sv
// Branch history table of 2-bit saturating counters.
// Ports: clk, rst_n, rd_idx_i/rd_ctr_o (comb read), wr_en_i/wr_idx_i/wr_taken_i.
module bht_2bit
  import pc_predict_unit_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic [1:0]       rd_ctr_o,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic             wr_taken_i
);

  logic [1:0] ctr_q [DEPTH];
  logic [1:0] cur;
  logic [1:0] ctr_d;

  assign rd_ctr_o = ctr_q[rd_idx_i];
  assign cur      = ctr_q[wr_idx_i];

  always_comb begin
    ctr_d = cur;
    if (wr_taken_i) begin
      if (cur != 2'b11) ctr_d = cur + 2'd1;
    end else begin
      if (cur != 2'b00) ctr_d = cur - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) ctr_q[i] <= BHT_INIT;
    end else if (wr_en_i) begin
      ctr_q[wr_idx_i] <= ctr_d;
    end
  end

endmodule

// File: rtl/pc_predict_unit.sv
// Fetch PC register with BHT prediction, EX-resolved redirect, stall/halt.
// Ports: fetch side (stall, halt, if_*, pc_out, pc_plus2, pred_taken), EX side (ex_*, flush), halted.
module pc_predict_unit
  import pc_predict_unit_pkg::*;
#(
  parameter int              PC_W      = 16,
  parameter int              IMM_W     = 9,
  parameter int              BHT_DEPTH = 16,
  parameter logic [PC_W-1:0] RESET_PC  = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             halt,
  input  logic             if_is_branch,
  input  logic [IMM_W-1:0] if_imm,
  output logic [PC_W-1:0]  pc_out,
  output logic [PC_W-1:0]  pc_plus2,
  output logic             pred_taken,
  input  logic             ex_valid,
  input  logic [PC_W-1:0]  ex_pc,
  input  logic [IMM_W-1:0] ex_imm,
  input  logic [2:0]       ex_cond,
  input  logic [2:0]       ex_flags,
  input  logic             ex_pred_taken,
  output logic             flush,
  output logic             halted
);

  localparam int IDX_W = $clog2(BHT_DEPTH);

  logic [PC_W-1:0] pc_q, pc_d;
  logic            halted_q, halted_d;
  logic [1:0]      rd_ctr;
  logic [PC_W-1:0] if_off, ex_off;
  logic [PC_W-1:0] if_tgt, ex_tgt;
  logic [PC_W-1:0] ex_plus2, redir;
  logic            actual;

  // Offsets are in words: sign-extend, then scale to bytes.
  assign if_off = {{(PC_W-IMM_W){if_imm[IMM_W-1]}}, if_imm} << 1;
  assign ex_off = {{(PC_W-IMM_W){ex_imm[IMM_W-1]}}, ex_imm} << 1;

  assign pc_plus2 = pc_q + PC_W'(2);
  assign ex_plus2 = ex_pc + PC_W'(2);
  assign if_tgt   = pc_plus2 + if_off;
  assign ex_tgt   = ex_plus2 + ex_off;

  assign actual = cond_eval(ex_cond, ex_flags);
  assign flush  = rst_n & ex_valid & (actual != ex_pred_taken);
  assign redir  = actual ? ex_tgt : ex_plus2;

  bht_2bit #(
    .DEPTH (BHT_DEPTH),
    .IDX_W (IDX_W)
  ) u_bht (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_idx_i   (pc_q[IDX_W:1]),
    .rd_ctr_o   (rd_ctr),
    .wr_en_i    (ex_valid),
    .wr_idx_i   (ex_pc[IDX_W:1]),
    .wr_taken_i (actual)
  );

  assign pred_taken = if_is_branch & rd_ctr[1];

  // A flush outranks halt so a wrong-path HLT cannot freeze fetch.
  always_comb begin
    pc_d     = pc_q;
    halted_d = halted_q;
    if (flush) begin
      pc_d     = redir;
      halted_d = 1'b0;
    end else if (halted_q || halt) begin
      halted_d = 1'b1;
    end else if (stall) begin
      pc_d = pc_q;
    end else if (pred_taken) begin
      pc_d = if_tgt;
    end else begin
      pc_d = pc_plus2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= RESET_PC;
      halted_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      halted_q <= halted_d;
    end
  end

  assign pc_out = pc_q;
  assign halted = halted_q;

endmodule

// File: tb/tb_pc_predict_unit.sv
// Directed bench for pc_predict_unit: fetch, mispredict, wrap, halt,
// stall/flush priority, counter saturation and reset abort.
module tb_pc_predict_unit;
  import pc_predict_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, halt, if_is_branch;
  logic [8:0]  if_imm;
  logic [15:0] pc_out, pc_plus2;
  logic        pred_taken;
  logic        ex_valid;
  logic [15:0] ex_pc;
  logic [8:0]  ex_imm;
  logic [2:0]  ex_cond, ex_flags;
  logic        ex_pred_taken;
  logic        flush, halted;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  pc_predict_unit #(
    .PC_W      (16),
    .IMM_W     (9),
    .BHT_DEPTH (16),
    .RESET_PC  (16'h0000)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .halt          (halt),
    .if_is_branch  (if_is_branch),
    .if_imm        (if_imm),
    .pc_out        (pc_out),
    .pc_plus2      (pc_plus2),
    .pred_taken    (pred_taken),
    .ex_valid      (ex_valid),
    .ex_pc         (ex_pc),
    .ex_imm        (ex_imm),
    .ex_cond       (ex_cond),
    .ex_flags      (ex_flags),
    .ex_pred_taken (ex_pred_taken),
    .flush         (flush),
    .halted        (halted)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stall = 0; halt = 0;
    if_is_branch = 0; if_imm = '0;
    ex_valid = 0; ex_pc = '0; ex_imm = '0;
    ex_cond = '0; ex_flags = '0;
    ex_pred_taken = 0;
  endtask

  // Redirect fetch to t via a not-taken mispredict at t-2.
  task automatic goto(input logic [15:0] t);
    ex_valid = 1; ex_pc = t - 16'd2; ex_imm = '0;
    ex_cond = COND_EQ; ex_flags = 3'b000;
    ex_pred_taken = 1;
    tick();
    ex_valid = 0; ex_pred_taken = 0;
    nvec++;
    if (pc_out !== t) begin
      nerr++;
      $display("FAIL goto pc=%h exp=%h", pc_out, t);
    end
  endtask

  task automatic test_reset();
    rst_n = 0;
    idle();
    if_is_branch = 1;
    #1;
    nvec++;
    if (pc_out !== 16'h0000) begin
      nerr++; $display("FAIL rst_pc got=%h exp=0000", pc_out);
    end
    nvec++;
    if (halted !== 1'b0) begin
      nerr++; $display("FAIL rst_halted got=%b exp=0", halted);
    end
    nvec++;
    if (flush !== 1'b0 || pred_taken !== 1'b0) begin
      nerr++;
      $display("FAIL rst_flush_pred got=%b%b exp=00", flush, pred_taken);
    end
    repeat (2) @(posedge clk);
    if_is_branch = 0;
    @(negedge clk);
    rst_n = 1;
    #1;
    for (int i = 0; i < 4; i++) begin
      logic [15:0] e;
      e = 16'(2 * i);
      nvec++;
      if (pc_out !== e) begin
        nerr++; $display("FAIL seq%0d got=%h exp=%h", i, pc_out, e);
      end
      tick();
    end
  endtask

  task automatic test_mispredict();
    goto(16'h0010);
    if_is_branch = 1; if_imm = 9'd3;
    #1;
    nvec++;
    if (pred_taken !== 1'b0) begin
      nerr++; $display("FAIL mp_pred0 got=%b exp=0", pred_taken);
    end
    tick();
    nvec++;
    if (pc_out !== 16'h0012) begin
      nerr++; $display("FAIL mp_fall got=%h exp=0012", pc_out);
    end
    if_is_branch = 0;
    ex_valid = 1; ex_pc = 16'h0010; ex_imm = 9'd3;
    ex_cond = COND_UNC; ex_pred_taken = 0;
    #1;
    nvec++;
    if (flush !== 1'b1) begin
      nerr++; $display("FAIL mp_flush got=%b exp=1", flush);
    end
    tick();
    ex_valid = 0;
    nvec++;
    if (pc_out !== 16'h0018) begin
      nerr++; $display("FAIL mp_redir got=%h exp=0018", pc_out);
    end
    goto(16'h0010);
    if_is_branch = 1; if_imm = 9'd3;
    #1;
    nvec++;
    if (pred_taken !== 1'b1) begin
      nerr++; $display("FAIL mp_pred1 got=%b exp=1", pred_taken);
    end
    tick();
    if_is_branch = 0;
    nvec++;
    if (pc_out !== 16'h0018) begin
      nerr++; $display("FAIL mp_tgt got=%h exp=0018", pc_out);
    end
  endtask

  task automatic test_backward();
    goto(16'h0020);
    ex_valid = 1; ex_pc = 16'h0020; ex_imm = 9'h1FC;
    ex_cond = COND_EQ; ex_flags = 3'b100;
    ex_pred_taken = 0;
    #1;
    nvec++;
    if (flush !== 1'b1) begin
      nerr++; $display("FAIL bk_flush got=%b exp=1", flush);
    end
    tick();
    ex_valid = 0; ex_flags = '0;
    nvec++;
    if (pc_out !== 16'h001A) begin
      nerr++; $display("FAIL bk_pc got=%h exp=001a", pc_out);
    end
  endtask

  task automatic test_wrap();
    goto(16'hFFFE);
    nvec++;
    if (pc_plus2 !== 16'h0000) begin
      nerr++; $display("FAIL wr_p2 got=%h exp=0000", pc_plus2);
    end
    tick();
    nvec++;
    if (pc_out !== 16'h0000) begin
      nerr++; $display("FAIL wr_pc got=%h exp=0000", pc_out);
    end
    stall = 1;
    ex_valid = 1; ex_pc = 16'hFFFE; ex_imm = 9'd1;
    ex_cond = COND_UNC; ex_pred_taken = 1;
    #1;
    nvec++;
    if (flush !== 1'b0) begin
      nerr++; $display("FAIL wr_noflush got=%b exp=0", flush);
    end
    repeat (3) tick();
    ex_valid = 0; ex_pred_taken = 0;
    nvec++;
    if (pc_out !== 16'h0000) begin
      nerr++; $display("FAIL wr_stall got=%h exp=0000", pc_out);
    end
    stall = 0;
    goto(16'hFFFE);
    if_is_branch = 1; if_imm = 9'd1;
    #1;
    nvec++;
    if (pred_taken !== 1'b1) begin
      nerr++; $display("FAIL wr_pred got=%b exp=1", pred_taken);
    end
    tick();
    if_is_branch = 0;
    nvec++;
    if (pc_out !== 16'h0002) begin
      nerr++; $display("FAIL wr_tgt got=%h exp=0002", pc_out);
    end
  endtask

  task automatic test_halt();
    goto(16'h0030);
    halt = 1;
    tick();
    halt = 0;
    for (int i = 0; i < 10; i++) begin
      nvec++;
      if (pc_out !== 16'h0030 || halted !== 1'b1) begin
        nerr++;
        $display("FAIL hlt%0d pc=%h h=%b exp=0030/1", i, pc_out, halted);
      end
      tick();
    end
    halt = 1;
    ex_valid = 1; ex_pc = 16'h002C; ex_imm = 9'd2;
    ex_cond = COND_UNC; ex_pred_taken = 0;
    #1;
    nvec++;
    if (flush !== 1'b1) begin
      nerr++; $display("FAIL hlt_flush got=%b exp=1", flush);
    end
    tick();
    halt = 0; ex_valid = 0;
    nvec++;
    if (pc_out !== 16'h0032 || halted !== 1'b0) begin
      nerr++;
      $display("FAIL hlt_rel pc=%h h=%b exp=0032/0", pc_out, halted);
    end
  endtask

  task automatic test_stall_flush();
    stall = 1;
    ex_valid = 1; ex_pc = 16'h0040; ex_imm = '0;
    ex_cond = COND_EQ; ex_flags = 3'b000;
    ex_pred_taken = 1;
    #1;
    nvec++;
    if (flush !== 1'b1) begin
      nerr++; $display("FAIL sf_flush got=%b exp=1", flush);
    end
    tick();
    stall = 0; ex_valid = 0; ex_pred_taken = 0;
    nvec++;
    if (pc_out !== 16'h0042) begin
      nerr++; $display("FAIL sf_pc got=%h exp=0042", pc_out);
    end
  endtask

  task automatic test_saturation();
    logic exp_p [5];
    exp_p[0] = 1; exp_p[1] = 1; exp_p[2] = 1;
    exp_p[3] = 1; exp_p[4] = 0;
    goto(16'h0026);
    stall = 1;
    if_is_branch = 1; if_imm = '0;
    ex_valid = 1; ex_pc = 16'h0106; ex_imm = '0;
    ex_cond = COND_UNC; ex_pred_taken = 1;
    #1;
    nvec++;
    if (pred_taken !== 1'b0) begin
      nerr++; $display("FAIL sat_old got=%b exp=0", pred_taken);
    end
    for (int i = 0; i < 5; i++) begin
      if (i == 3) begin
        ex_cond = COND_EQ; ex_flags = 3'b000;
        ex_pred_taken = 0;
      end
      tick();
      nvec++;
      if (pred_taken !== exp_p[i]) begin
        nerr++;
        $display("FAIL sat%0d got=%b exp=%b", i, pred_taken, exp_p[i]);
      end
    end
    ex_valid = 0; stall = 0; if_is_branch = 0;
    nvec++;
    if (pc_out !== 16'h0026) begin
      nerr++; $display("FAIL sat_pc got=%h exp=0026", pc_out);
    end
  endtask

  task automatic test_reset_abort();
    ex_valid = 1; ex_pc = 16'h0050; ex_imm = '0;
    ex_cond = COND_UNC; ex_pred_taken = 0;
    #1;
    nvec++;
    if (flush !== 1'b1) begin
      nerr++; $display("FAIL ra_pre got=%b exp=1", flush);
    end
    rst_n = 0;
    #1;
    nvec++;
    if (flush !== 1'b0 || pc_out !== 16'h0000) begin
      nerr++;
      $display("FAIL ra_rst fl=%b pc=%h exp=0/0000", flush, pc_out);
    end
    tick();
    idle();
  endtask

  initial begin
    test_reset();
    test_mispredict();
    test_backward();
    test_wrap();
    test_halt();
    test_stall_flush();
    test_saturation();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/pc_predict_unit.md
# pc_predict_unit

Fetch-stage program-counter unit for the pipelined 16-bit core. Holds the PC register and computes the next fetch address. A BHT_DEPTH-entry table of 2-bit saturating counters predicts PC-relative branches at fetch. Branches resolved in EX against the condition flags update the table, and a mispredict redirects fetch. The unit also handles stall, halt, and flush.

## Interface
Parameters:
- PC_W, 16, PC and address width
- IMM_W, 9, branch offset width (signed, in 16-bit words)
- BHT_DEPTH, 16, predictor entries (power of two, ≥2)
- RESET_PC, 16'h0000, PC value after reset

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- stall  in  1  hold PC (hazard unit)
- halt  in  1  fetched instruction is HLT
- if_is_branch  in  1  fetched instruction is a conditional/unconditional B
- if_imm  in  IMM_W  offset of fetched branch
- pc_out  out  PC_W  current fetch PC
- pc_plus2  out  PC_W  pc_out+2
- pred_taken  out  1  prediction for current fetch
- ex_valid  in  1  branch resolving in EX (one-cycle pulse per branch)
- ex_pc, ex_imm  in  PC_W, IMM_W  PC and offset of resolving branch
- ex_cond  in  3  condition code
- ex_flags  in  3  {Z,V,N}
- ex_pred_taken  in  1  prediction carried down the pipe
- flush  out  1  mispredict; younger stages must squash
- halted  out  1  PC frozen by HLT

## Operation
- Target = base+2 + (sign_extend(imm) << 1), modulo 2^PC_W. The offset is sign-extended, not zero-extended. Base is pc_out at fetch and ex_pc at EX.
- Conditions:
  - 000 NEQ: !Z
  - 001 EQ: Z
  - 010 GT: !Z & !N
  - 011 LT: N
  - 100 GTE: Z | !N
  - 101 LTE: Z | N
  - 110 OVFL: V
  - 111 always taken
- BHT index is pc[log2(BHT_DEPTH):1]. Counter reset value is 2'b01 (weak not-taken).
- pred_taken = if_is_branch & counter[1], read combinationally from the pre-update value.
- On ex_valid, the counter at ex_pc's index saturates up (max 11) if actually taken, down (min 00) otherwise. A same-index read in the same cycle sees the old value.
- flush = rst_n & ex_valid & (actual_taken != ex_pred_taken).
- Redirect address = actual_taken ? EX target : ex_pc+2.
- Next-PC priority, highest first:
  1. flush: redirect address; also clears halted and ignores halt
  2. halted or halt: hold; set halted
  3. stall: hold
  4. pred_taken: fetch target
  5. otherwise: pc_out+2
- halted stays set until flush or reset. A wrong-path HLT must not freeze the core.
- BHT updates regardless of stall or halt.

## Timing
- Reset (async):
  - pc_out = RESET_PC
  - halted = 0
  - all counters = 01
  - flush = 0
  - pred_taken = 0
- pc_out, halted, and the BHT update on the rising edge of clk. flush, pred_taken, and pc_plus2 are combinational.
- Predicted-taken branch: target is fetched the next cycle (zero bubbles).
- Mispredict: flush is asserted in the EX-resolve cycle, and the corrected PC appears on the following edge.
- Reset asserted mid-operation aborts any redirect immediately. No BHT write happens while rst_n is low.

## Structure
- Shared package holds:
  - condition-code constants (COND_NEQ … COND_UNC)
  - flag bit positions (Z=2, V=1, N=0)
  - BHT_INIT = 2'b01
  - the cond-evaluate function, reused by EX
- One sub-module, bht_2bit: counter array with one combinational read port and one synchronous write port. It has its own async reset.

## Test plan
- Reset with RESET_PC=0 → pc_out=0, halted=0. After release with no branches → PC sequence 0x0000, 0x0002, 0x0004, 0x0006.
- Branch at 0x0010, imm=+3, counters reset:
  - At fetch → pred_taken=0, next PC 0x0012.
  - EX resolves cond=111 with ex_pred_taken=0 → flush=1, next PC 0x0018, counter becomes 10.
  - Refetch at 0x0010 → pred_taken=1, next PC 0x0018.
- Branch at 0x0020, imm=9'h1FC (-4), cond=001, Z=1, predicted 0 → flush, next PC 0x001A.
- pc_out=0xFFFE with no branch → 0x0000. Branch at 0xFFFE with imm=+1 predicted taken → 0x0002.
- Halt then flush:
  - halt at 0x0030 → PC stays 0x0030 and halted=1 for 10 cycles.
  - Then ex_pc=0x002C, cond=111, imm=2, ex_pred_taken=0 → flush=1, halted=0, next PC 0x0032.
- Stall and flush in the same cycle → flush wins.
- Saturation: three taken resolves at one index → 11. One not-taken → 10, still predicts taken.
